// File: rtl/seq_minmax_stream.sv
`default_nettype none
// ============================================================================
//  Module   : seq_minmax_stream
//  Purpose  : Serial min/max/count reducer for an unsigned sample stream.
//             Samples arrive one beat per clock over a valid/ready handshake
//             and a burst ends on in_last, or is truncated when it reaches
//             MAX_LEN beats without in_last. The burst result is presented
//             on a held valid/ready result port.
//  Ports    : clk, rst          - clock (rising edge), async active-high reset
//             in_valid/in_ready - sample handshake
//             in_data, in_last  - sample value, final-beat marker
//             out_valid/out_ready - result handshake (valid held until taken)
//             out_min, out_max  - burst minimum / maximum (unsigned)
//             out_cnt           - beats in burst, 1..MAX_LEN
//             out_trunc         - burst closed by MAX_LEN, not by in_last
//             out_min_idx       - 0-based beat index of the minimum
//                                 (only when SEQ_MINMAX_IDX_EN is defined)
//  Config   : SEQ_MINMAX_IDX_EN - adds out_min_idx and its index register
//  Revision : 1.0 - initial release
// ============================================================================
module seq_minmax_stream #(
    parameter int DW      = 8,
    parameter int MAX_LEN = 16,
    localparam int CW     = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_min,
    output logic [DW-1:0] out_max,
    output logic [CW-1:0] out_cnt,
`ifdef SEQ_MINMAX_IDX_EN
    output logic [CW-1:0] out_min_idx,
`endif
    output logic          out_trunc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [CW-1:0] C_MAX_LEN = CW'(MAX_LEN);
    localparam logic [CW-1:0] C_ONE     = CW'(1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [DW-1:0] r_min;
    logic [DW-1:0] r_max;
    logic [CW-1:0] r_cnt;
    logic          r_trunc;
    logic          w_beat;
    logic [CW-1:0] w_cnt_inc;
    logic          w_at_max;

    assign w_beat    = in_valid & in_ready;
    assign w_cnt_inc = r_cnt + C_ONE;
    // Beat being accepted now would be the MAX_LEN-th of the burst.
    assign w_at_max  = (w_cnt_inc == C_MAX_LEN);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_beat) begin
                    w_state_nxt = in_last ? S_HOLD : S_ACC;
                end
            end
            S_ACC: begin
                if (w_beat && (in_last || w_at_max)) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. in_ready is forced low while rst is high so no beat
    // can be seen by the upstream during reset.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (r_state != S_HOLD) & ~rst;
        out_valid = (r_state == S_HOLD);
    end

    // ------------------------------------------------------------------
    // Result datapath: updates only on accepted beats, so results remain
    // visible after HOLD exits until the next burst's first beat.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min   <= '0;
            r_max   <= '0;
            r_cnt   <= '0;
            r_trunc <= 1'b0;
        end else if (w_beat) begin
            if (r_state == S_IDLE) begin
                r_min   <= in_data;
                r_max   <= in_data;
                r_cnt   <= C_ONE;
                r_trunc <= 1'b0;
            end else begin
                // Strict compares: on a tie the earlier sample is kept.
                if (in_data < r_min) begin
                    r_min <= in_data;
                end
                if (in_data > r_max) begin
                    r_max <= in_data;
                end
                r_cnt   <= w_cnt_inc;
                r_trunc <= w_at_max & ~in_last;
            end
        end
    end

    assign out_min   = r_min;
    assign out_max   = r_max;
    assign out_cnt   = r_cnt;
    assign out_trunc = r_trunc;

`ifdef SEQ_MINMAX_IDX_EN
    logic [CW-1:0] r_min_idx;

    // The index of the beat being accepted equals the count so far.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min_idx <= '0;
        end else if (w_beat) begin
            if (r_state == S_IDLE) begin
                r_min_idx <= '0;
            end else if (in_data < r_min) begin
                r_min_idx <= r_cnt;
            end
        end
    end

    assign out_min_idx = r_min_idx;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_minmax_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_minmax_stream
//  Purpose  : Self-checking bench for seq_minmax_stream. Every accepted beat
//             is fed to a burst-level reference model (queue of samples,
//             reduced with plain loops when the burst closes); the expected
//             results queue also predicts in_ready / out_valid.
//  Config   : SEQ_MINMAX_IDX_EN - also checks out_min_idx
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_minmax_stream;

    localparam int DW      = 8;
    localparam int MAX_LEN = 16;
    localparam int CW      = $clog2(MAX_LEN + 1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_min;
    logic [DW-1:0] out_max;
    logic [CW-1:0] out_cnt;
    logic          out_trunc;
`ifdef SEQ_MINMAX_IDX_EN
    logic [CW-1:0] out_min_idx;
`endif

    seq_minmax_stream #(
        .DW      (DW),
        .MAX_LEN (MAX_LEN)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_min     (out_min),
        .out_max     (out_max),
        .out_cnt     (out_cnt),
`ifdef SEQ_MINMAX_IDX_EN
        .out_min_idx (out_min_idx),
`endif
        .out_trunc   (out_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int mn;
        int mx;
        int cnt;
        int trunc;
        int idx;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    int   bq[$];      // samples of the burst in progress
    res_t exp_q[$];   // completed bursts awaiting transfer
    bit   beat_seen;
    bit   rand_rdy = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Close the burst when in_last arrives or MAX_LEN samples are held.
    task automatic model_beat(input int d, input bit last);
        res_t r;
        bq.push_back(d);
        if (last || bq.size() == MAX_LEN) begin
            r.mn = bq[0]; r.mx = bq[0]; r.idx = 0;
            for (int i = 1; i < bq.size(); i++) begin
                if (bq[i] < r.mn) begin r.mn = bq[i]; r.idx = i; end
                if (bq[i] > r.mx) r.mx = bq[i];
            end
            r.cnt   = bq.size();
            r.trunc = last ? 0 : 1;
            exp_q.push_back(r);
            bq.delete();
        end
    endtask

    // One clock: sample at negedge, compare, advance model, resume at posedge+1.
    task automatic step();
        bit pend;
        @(negedge clk);
        pend = (exp_q.size() != 0);
        check_val("in_ready", 32'(in_ready), 32'(!pend));
        check_val("out_valid", 32'(out_valid), 32'(pend));
        if (out_valid && pend) begin
            check_val("out_min", 32'(out_min), 32'(exp_q[0].mn));
            check_val("out_max", 32'(out_max), 32'(exp_q[0].mx));
            check_val("out_cnt", 32'(out_cnt), 32'(exp_q[0].cnt));
            check_val("out_trunc", 32'(out_trunc), 32'(exp_q[0].trunc));
`ifdef SEQ_MINMAX_IDX_EN
            check_val("out_min_idx", 32'(out_min_idx), 32'(exp_q[0].idx));
`endif
        end
        beat_seen = in_valid && in_ready;
        if (out_valid && out_ready && pend) void'(exp_q.pop_front());
        if (beat_seen) model_beat(int'(in_data), in_last);
        @(posedge clk);
        #1;
    endtask

    // Offer one sample until accepted; gap_pct = chance of an idle cycle.
    task automatic push_beat(input logic [DW-1:0] d, input bit last, input int gap_pct);
        int tries = 0;
        forever begin
            if (rand_rdy) out_ready = 1'($urandom);
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            if (in_valid) begin
                in_data = d;
                in_last = last;
            end else begin
                in_data = DW'($urandom);
                in_last = 1'($urandom);
            end
            step();
            if (beat_seen) break;
            tries++;
            if (tries > 200) begin
                total++; bad++;
                $display("FAIL beat_timeout: got no accept expected accept (t=%0t)", $time);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'(0));
        check_val({tag, "_out_min"}, 32'(out_min), 32'(0));
        check_val({tag, "_out_max"}, 32'(out_max), 32'(0));
        check_val({tag, "_out_cnt"}, 32'(out_cnt), 32'(0));
        check_val({tag, "_out_trunc"}, 32'(out_trunc), 32'(0));
`ifdef SEQ_MINMAX_IDX_EN
        check_val({tag, "_out_min_idx"}, 32'(out_min_idx), 32'(0));
`endif
    endtask

    // Asynchronous reset pulse away from the clock edge; model drops everything.
    task automatic pulse_reset(input string tag);
        #1 rst = 1'b1;
        #1 check_reset_outputs(tag);
        bq.delete();
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [DW-1:0] v1 [4];
        logic [DW-1:0] v3 [4];
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Mixed burst, minimum at index 1
        v1 = '{8'h30, 8'h05, 8'hF0, 8'h22};
        for (int i = 0; i < 4; i++) push_beat(v1[i], i == 3, 0);
        drain();

        // Single-beat burst
        push_beat(8'h7A, 1'b1, 0);
        drain();

        // Ties keep the earliest index; extreme values
        for (int i = 0; i < 3; i++) push_beat(8'h10, i == 2, 0);
        drain();
        v3 = '{8'h80, 8'h00, 8'hFF, 8'h7F};
        for (int i = 0; i < 4; i++) push_beat(v3[i], i == 3, 0);
        drain();

        // Truncation at MAX_LEN; 17th beat opens a new burst
        for (int i = 1; i <= MAX_LEN; i++) push_beat(DW'(i), 1'b0, 0);
        push_beat(8'h99, 1'b1, 0);
        drain();

        // last arriving exactly on the MAX_LEN-th beat is not a truncation
        for (int i = 1; i <= MAX_LEN; i++) push_beat(DW'(100 - i), i == MAX_LEN, 0);
        drain();

        // Backpressure in HOLD: outputs frozen, in_ready low
        out_ready = 1'b0;
        push_beat(8'h21, 1'b0, 0);
        push_beat(8'h09, 1'b1, 0);
        repeat (5) step();
        out_ready = 1'b1;
        step();
        step();

        // Reset mid-burst, then mid-HOLD
        push_beat(8'h11, 1'b0, 0);
        push_beat(8'h22, 1'b0, 0);
        pulse_reset("rst_burst");
        push_beat(8'h44, 1'b1, 0);
        drain();
        out_ready = 1'b0;
        push_beat(8'h55, 1'b1, 0);
        step();
        pulse_reset("rst_hold");
        out_ready = 1'b1;
        step();

        // Gappy in_valid on a 3-beat burst
        push_beat(8'h40, 1'b0, 50);
        push_beat(8'h02, 1'b0, 50);
        push_beat(8'hC8, 1'b1, 50);
        drain();

        // Random bursts, some longer than MAX_LEN, random gaps and out_ready
        rand_rdy = 1'b1;
        for (int b = 0; b < 14; b++) begin
            int len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) push_beat(DW'($urandom), i == len - 1, 50);
        end
        rand_rdy = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
